// File: rtl/afe_frame_sched.sv
// Frame scheduler: after a trigger it waits out the exposure, then issues one line start per TFT row and waits for each line to finish.
// Latency: the first LINE_START comes EXP_CYCLES+1 edges after trigger accept; each later one comes 1 cycle after AFE_LINE_DONE if the buffer is ready.
// Backpressure: waits in LINE_REQ with no timeout while ADS_BUF_READY=0; a line watchdog aborts the frame if AFE_LINE_DONE never arrives.
module afe_frame_sched #(
    parameter int ROW_NUM      = 64,
    parameter int ROW_W        = 8,
    parameter int EXP_CYCLES   = 1000,
    parameter int LINE_TIMEOUT = 16384,
    parameter int CNT_W        = 16
) (
    input  logic             CLK_100M,
    input  logic             CLK_RST,
    input  logic             ADS_INIT_OK,
    input  logic             FRAME_TRIG,
    input  logic             ADS_BUF_READY,
    input  logic             AFE_LINE_DONE,
    output logic             LINE_START,
    output logic [ROW_W-1:0] ROW_ADDR,
    output logic             GATE_ON,
    output logic             FRAME_BUSY,
    output logic             FRAME_DONE,
    output logic             TRIG_MISS,
    output logic             ERR_TIMEOUT
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EXPOSE    = 3'd1;
    localparam logic [2:0] S_LINE_REQ  = 3'd2;
    localparam logic [2:0] S_LINE_WAIT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(LINE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROW_NUM - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;          // exposure counter and line watchdog share one counter
    logic [ROW_W-1:0] r_row;
    logic             r_line_start;
    logic             r_gate_on;
    logic             r_frame_busy;
    logic             r_frame_done;
    logic             r_trig_miss;
    logic             r_err_timeout;

    logic w_abort;
    logic w_trig_accept;
    logic w_trig_reject;
    logic w_exp_end;
    logic w_wdog_end;
    logic w_last_row;

    // Losing ADC init mid-frame overrides everything else, including a trigger
    // rejection, because every pulse output returns to its reset value.
    assign w_abort       = (r_state != S_IDLE) && !ADS_INIT_OK;
    assign w_trig_accept = FRAME_TRIG && ADS_INIT_OK && (r_state == S_IDLE);
    assign w_trig_reject = FRAME_TRIG && !w_trig_accept && !w_abort;
    assign w_exp_end     = (r_cnt == EXP_LAST);
    assign w_wdog_end    = (r_cnt == WDOG_LAST);
    assign w_last_row    = (r_row == ROW_LAST);

    // Frame sequencing: exposure, then a request/wait handshake per row, and an abort on init loss or watchdog expiry.
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_row         <= '0;
            r_line_start  <= 1'b0;
            r_gate_on     <= 1'b0;
            r_frame_busy  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_trig_miss   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_line_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_trig_miss  <= w_trig_reject;
            if (w_abort) begin
                // ERR_TIMEOUT is deliberately left alone so a prior watchdog error survives.
                r_state      <= S_IDLE;
                r_cnt        <= '0;
                r_row        <= '0;
                r_gate_on    <= 1'b0;
                r_frame_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_trig_accept) begin
                            r_state       <= S_EXPOSE;
                            r_cnt         <= '0;
                            r_row         <= '0;
                            r_err_timeout <= 1'b0;
                            r_frame_busy  <= 1'b1;
                        end
                    end
                    S_EXPOSE: begin
                        if (w_exp_end) begin
                            r_state <= S_LINE_REQ;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_LINE_REQ: begin
                        if (ADS_BUF_READY) begin
                            r_state      <= S_LINE_WAIT;
                            r_cnt        <= '0;
                            r_line_start <= 1'b1;
                            r_gate_on    <= 1'b1;
                        end
                    end
                    S_LINE_WAIT: begin
                        // A completion that arrives on the terminal count still counts as on time.
                        if (AFE_LINE_DONE) begin
                            r_gate_on <= 1'b0;
                            r_cnt     <= '0;
                            if (w_last_row) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_row   <= r_row + ROW_ONE;
                                r_state <= S_LINE_REQ;
                            end
                        end else if (w_wdog_end) begin
                            r_state       <= S_IDLE;
                            r_cnt         <= '0;
                            r_row         <= '0;
                            r_gate_on     <= 1'b0;
                            r_frame_busy  <= 1'b0;
                            r_err_timeout <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_DONE: begin
                        r_state      <= S_IDLE;
                        r_row        <= '0;
                        r_frame_busy <= 1'b0;
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_row        <= '0;
                        r_gate_on    <= 1'b0;
                        r_frame_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LINE_START  = r_line_start;
    assign ROW_ADDR    = r_row;
    assign GATE_ON     = r_gate_on;
    assign FRAME_BUSY  = r_frame_busy;
    assign FRAME_DONE  = r_frame_done;
    assign TRIG_MISS   = r_trig_miss;
    assign ERR_TIMEOUT = r_err_timeout;

endmodule

// File: tb/tb_afe_frame_sched.sv
// Bench for afe_frame_sched: a cycle model built from the frame rules is checked against every output on every cycle, with directed scenarios pinned by literal timings.
// Latency: the model updates on posedge, and the DUT is compared on negedge.
// Backpressure: ADS_BUF_READY is driven by directed holds and by random duty, and the line sequencer responder has a programmable delay.
module tb_afe_frame_sched;

    localparam int ROWS = 4;
    localparam int EXPC = 10;
    localparam int TMO  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_ok;
    logic       trig;
    logic       buf_rdy;
    logic       line_done;
    logic       line_start;
    logic [7:0] row_addr;
    logic       gate_on;
    logic       busy;
    logic       fdone;
    logic       tmiss;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    afe_frame_sched #(
        .ROW_NUM(ROWS), .ROW_W(8), .EXP_CYCLES(EXPC), .LINE_TIMEOUT(TMO), .CNT_W(16)
    ) dut (
        .CLK_100M(clk), .CLK_RST(rst), .ADS_INIT_OK(init_ok), .FRAME_TRIG(trig),
        .ADS_BUF_READY(buf_rdy), .AFE_LINE_DONE(line_done), .LINE_START(line_start),
        .ROW_ADDR(row_addr), .GATE_ON(gate_on), .FRAME_BUSY(busy), .FRAME_DONE(fdone),
        .TRIG_MISS(tmiss), .ERR_TIMEOUT(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_EXP, P_REQ, P_WAIT, P_DONE} ph_t;
    ph_t m_ph = P_IDLE;
    int  exp_left = 0;   // exposure cycles still to wait
    int  age      = 0;   // cycles spent waiting on the current line
    int  m_row = 0;
    bit  m_start = 0, m_gate = 0, m_busy = 0, m_done = 0, m_miss = 0, m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = P_IDLE; m_row = 0; exp_left = 0; age = 0;
            m_start = 0; m_gate = 0; m_busy = 0; m_done = 0; m_miss = 0; m_err = 0;
        end else begin
            m_start = 0; m_done = 0; m_miss = 0;
            if (m_ph != P_IDLE && !init_ok) begin
                m_ph = P_IDLE; m_row = 0; m_gate = 0; m_busy = 0;
            end else begin
                if (trig && (m_ph != P_IDLE || !init_ok)) m_miss = 1;
                case (m_ph)
                    P_IDLE: if (trig && init_ok) begin
                        m_ph = P_EXP; exp_left = EXPC; m_row = 0; m_err = 0; m_busy = 1;
                    end
                    P_EXP: begin
                        exp_left--;
                        if (exp_left == 0) m_ph = P_REQ;
                    end
                    P_REQ: if (buf_rdy) begin
                        m_ph = P_WAIT; age = 0; m_start = 1; m_gate = 1;
                    end
                    P_WAIT: begin
                        age++;
                        if (line_done) begin
                            m_gate = 0;
                            if (m_row == ROWS - 1) begin m_ph = P_DONE; m_done = 1; end
                            else begin m_row++; m_ph = P_REQ; end
                        end else if (age == TMO) begin
                            m_ph = P_IDLE; m_err = 1; m_gate = 0; m_busy = 0; m_row = 0;
                        end
                    end
                    P_DONE: begin m_ph = P_IDLE; m_busy = 0; m_row = 0; end
                    default: m_ph = P_IDLE;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("line_start", line_start, m_start);
        chk("row_addr", row_addr, m_row);
        chk("gate_on", gate_on, m_gate);
        chk("frame_busy", busy, m_busy);
        chk("frame_done", fdone, m_done);
        chk("trig_miss", tmiss, m_miss);
        chk("err_timeout", err, m_err);
    end

    // ---------------- line sequencer responder ----------------
    int line_delay = 20;   // AFE_LINE_DONE is sampled this many edges after LINE_START
    int hold_row   = -1;   // the row whose completion is withheld
    int cd         = 0;
    bit spur_en    = 0;
    always @(negedge clk) begin
        line_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) line_done = 1'b1;
        end
        if (line_start) cd = (int'(row_addr) == hold_row) ? 0 : line_delay - 1;
        if (spur_en && $urandom_range(0, 40) == 0) line_done = 1'b1;
    end

    // ---------------- event log ----------------
    int st_cyc[$];
    int st_row[$];
    int dn_cyc[$];
    int b_rise = 0, b_fall = 0;
    bit pb = 0;
    always @(negedge clk) begin
        if (line_start) begin st_cyc.push_back(cyc); st_row.push_back(int'(row_addr)); end
        if (fdone) dn_cyc.push_back(cyc);
        if (busy && !pb) b_rise = cyc;
        if (!busy && pb) b_fall = cyc;
        pb = busy;
    end

    // ---------------- helpers ----------------
    task automatic clear_log();
        st_cyc.delete(); st_row.delete(); dn_cyc.delete();
    endtask

    // t0 is the edge that samples the trigger.
    task automatic fire_trig(output int t0);
        @(negedge clk); trig = 1'b1; t0 = cyc + 1;
        @(negedge clk); trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk(nm, int'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_row_start(input int r, input string nm);
        int n = 0;
        while (!(line_start && int'(row_addr) == r) && n < 400) begin @(negedge clk); n++; end
        chk(nm, int'(n < 400), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, limit 60000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1; init_ok = 1'b0; trig = 1'b0; buf_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line_start", line_start, 0);
        chk("rst_row", row_addr, 0);
        chk("rst_gate", gate_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fdone, 0);
        chk("rst_err", err, 0);
        rst = 1'b0; init_ok = 1'b1; buf_rdy = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal frame: starts at t0+11, then every 21 cycles.
        clear_log();
        fire_trig(t0);
        wait_idle(400, "nom_idle");
        chk("nom_nstarts", st_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("nom_start_off", st_cyc[i] - t0, 11 + 21 * i);
            chk("nom_start_row", st_row[i], i);
        end
        chk("nom_ndone", dn_cyc.size(), 1);
        chk("nom_done_off", dn_cyc[0] - t0, 94);
        chk("nom_busy_rise", b_rise - t0, 0);
        chk("nom_busy_fall", b_fall - t0, 95);
        chk("nom_err", err, 0);

        // Backpressure after row 1 completes.
        clear_log();
        fire_trig(t0);
        wait_row_start(1, "bp_row1");
        repeat (19) @(negedge clk);
        buf_rdy = 1'b0;
        repeat (30) @(negedge clk);
        buf_rdy = 1'b1;
        wait_idle(400, "bp_idle");
        chk("bp_gap", st_cyc[2] - st_cyc[1], 50);
        chk("bp_ndone", dn_cyc.size(), 1);
        chk("bp_err", err, 0);

        // Watchdog on row 2.
        hold_row = 2;
        clear_log();
        fire_trig(t0);
        wait_row_start(2, "wd_row2");
        wait_idle(200, "wd_idle");
        chk("wd_err", err, 1);
        chk("wd_gate", gate_on, 0);
        chk("wd_ndone", dn_cyc.size(), 0);
        chk("wd_abort_off", b_fall - st_cyc[2], 50);
        hold_row = -1;
        fire_trig(t0);
        chk("wd_err_cleared", err, 0);
        wait_idle(400, "wd_idle2");

        // Completion exactly on the watchdog terminal cycle.
        line_delay = 50;
        clear_log();
        fire_trig(t0);
        wait_idle(600, "bnd_idle");
        chk("bnd_err", err, 0);
        chk("bnd_ndone", dn_cyc.size(), 1);
        chk("bnd_gap", st_cyc[1] - st_cyc[0], 51);
        line_delay = 20;

        // Trigger rules.
        init_ok = 1'b0;
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        chk("miss_noinit", tmiss, 1);
        chk("miss_noinit_busy", busy, 0);
        init_ok = 1'b1;
        clear_log();
        fire_trig(t0);
        wait_row_start(1, "tw_row1");
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
        chk("miss_in_wait", tmiss, 1);
        wait_idle(400, "tw_idle");
        chk("tw_ndone", dn_cyc.size(), 1);
        chk("tw_nstarts", st_cyc.size(), 4);

        // Init loss during row 1.
        fire_trig(t0);
        wait_row_start(1, "ab_row1");
        init_ok = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_row", row_addr, 0);
        chk("ab_gate", gate_on, 0);
        chk("ab_start", line_start, 0);
        init_ok = 1'b1;
        repeat (30) @(negedge clk);

        // Reset during exposure, then a full frame.
        fire_trig(t0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_busy", busy, 0);
        chk("rs_row", row_addr, 0);
        clear_log();
        fire_trig(t0);
        wait_row_start(0, "rs_row0");
        chk("rs_first_off", cyc - t0, 11);
        wait_idle(400, "rs_idle");
        chk("rs_ndone", dn_cyc.size(), 1);
        chk("rs_nstarts", st_cyc.size(), 4);

        // Reset while LINE_START is high cuts the gate.
        fire_trig(t0);
        wait_row_start(0, "rl_row0");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rl_gate", gate_on, 0);
        chk("rl_start", line_start, 0);
        repeat (30) @(negedge clk);

        // Randomized phase, checked by the per-cycle model comparison.
        spur_en = 1;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if (i % 150 == 0) begin
                line_delay = $urandom_range(2, 60);
                hold_row   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            end
            trig    = ($urandom_range(0, 99) < 3);
            init_ok = ($urandom_range(0, 999) >= 2);
            buf_rdy = ($urandom_range(0, 99) < 70);
            rst     = ($urandom_range(0, 1999) == 0);
        end
        @(negedge clk);
        rst = 1'b0; trig = 1'b0; init_ok = 1'b1; buf_rdy = 1'b1;
        spur_en = 0; hold_row = -1; line_delay = 20;
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afe_frame_sched.md
Name: afe_frame_sched

Overview:
- Frame-level scheduler above the per-line AFE sequencer.
- On a frame trigger it waits a fixed exposure time, then issues one line-start request per TFT row. Each request is gated on downstream ADS buffer readiness, and the scheduler waits for the line sequencer's completion pulse before moving on.
- Reports frame busy/done, supervises each line with a watchdog, and drives the TFT row address and gate enable.

Parameters:
- ROW_NUM, 64, rows per frame (≥1).
- ROW_W, 8, width of ROW_ADDR; 2^ROW_W ≥ ROW_NUM.
- EXP_CYCLES, 1000, exposure wait in CLK_100M cycles (10 us); ≥1.
- LINE_TIMEOUT, 16384, max cycles in LINE_WAIT before abort; ≥2.
- CNT_W, 16, width of the shared exposure/watchdog counter.

Ports:
- CLK_100M  in  1  system clock, 100 MHz.
- CLK_RST  in  1  synchronous reset, active-high.
- ADS_INIT_OK  in  1  ADC init complete; level.
- FRAME_TRIG  in  1  frame request; one-cycle pulse.
- ADS_BUF_READY  in  1  downstream line buffer can accept a line; level.
- AFE_LINE_DONE  in  1  line sequencer finished the SHS phase; one-cycle pulse.
- LINE_START  out  1  one-cycle start pulse to the line sequencer.
- ROW_ADDR  out  ROW_W  current TFT row index.
- GATE_ON  out  1  TFT gate enable for ROW_ADDR.
- FRAME_BUSY  out  1  high from trigger accept until return to IDLE.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes normally.
- TRIG_MISS  out  1  one-cycle pulse when FRAME_TRIG is rejected.
- ERR_TIMEOUT  out  1  sticky line-watchdog error flag.

Behaviour:
- Single clock, CLK_100M. Reset CLK_RST is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; all outputs 0, including ROW_ADDR, and counters 0.
- States: IDLE, EXPOSE, LINE_REQ, LINE_WAIT, DONE.
- IDLE:
  - FRAME_TRIG with ADS_INIT_OK=1 → EXPOSE on the next edge. Row=0, counter=0, ERR_TIMEOUT cleared, FRAME_BUSY=1 from that edge.
  - FRAME_TRIG with ADS_INIT_OK=0 → stay in IDLE and pulse TRIG_MISS.
- EXPOSE:
  - Counter increments each cycle.
  - When counter == EXP_CYCLES-1 → LINE_REQ and clear the counter.
  - Dwell is exactly EXP_CYCLES cycles.
- LINE_REQ:
  - While ADS_BUF_READY=0, hold with no timeout.
  - On a cycle where ADS_BUF_READY=1 → LINE_WAIT. On the same edge: LINE_START=1 for one cycle, GATE_ON=1, counter=0.
  - ROW_ADDR is stable before and during LINE_START.
- LINE_WAIT:
  - GATE_ON stays 1 and the counter increments.
  - On AFE_LINE_DONE: GATE_ON=0.
    - If ROW_ADDR == ROW_NUM-1 → DONE.
    - Otherwise ROW_ADDR+1 → LINE_REQ.
  - If the counter reaches LINE_TIMEOUT-1 without AFE_LINE_DONE → IDLE. Set ERR_TIMEOUT=1, GATE_ON=0, FRAME_BUSY=0, ROW_ADDR=0, no FRAME_DONE.
  - AFE_LINE_DONE in the same cycle as the timeout terminal count: AFE_LINE_DONE wins and no error is raised.
- DONE:
  - FRAME_DONE=1 for one cycle.
  - Next edge → IDLE with FRAME_BUSY=0 and ROW_ADDR=0.
- Minimum LINE_START spacing: ADS_BUF_READY=1 allows a re-issue 1 cycle after AFE_LINE_DONE (LINE_WAIT→LINE_REQ→LINE_WAIT).
- FRAME_TRIG in any state other than IDLE is ignored and pulses TRIG_MISS.
- AFE_LINE_DONE outside LINE_WAIT is ignored.
- ADS_INIT_OK falling in any non-IDLE state aborts to IDLE on the next edge:
  - all outputs return to reset values except ERR_TIMEOUT, which holds;
  - no FRAME_DONE and no error.
- Reset mid-frame: all outputs at reset values on the next edge; an in-flight LINE_START pulse is cut.
- Counter arithmetic: unsigned, CNT_W bits, never wraps (bounded by the terminal compares). ROW_ADDR never exceeds ROW_NUM-1.

Test Plan:
- Nominal frame (ROW_NUM=4, EXP_CYCLES=10, LINE_TIMEOUT=50; ADS_BUF_READY=1; AFE_LINE_DONE 20 cycles after each LINE_START) → 4 LINE_STARTs, the first 11 cycles after the trigger. ROW_ADDR=0,1,2,3. FRAME_DONE pulses once. FRAME_BUSY spans trigger+1 to FRAME_DONE+1. ERR_TIMEOUT=0.
- Backpressure: drop ADS_BUF_READY for 30 cycles after row 1 completes → no LINE_START for row 2 until 1 cycle after ADS_BUF_READY rises. No timeout.
- Watchdog: withhold AFE_LINE_DONE on row 2 → after 50 cycles in LINE_WAIT: ERR_TIMEOUT=1, GATE_ON=0, IDLE, no FRAME_DONE. The next accepted trigger clears ERR_TIMEOUT.
- Boundary: AFE_LINE_DONE exactly on the 50th LINE_WAIT cycle → no error, advance to the next row.
- Trigger rules: FRAME_TRIG with ADS_INIT_OK=0 → TRIG_MISS, FRAME_BUSY stays 0. FRAME_TRIG during LINE_WAIT → TRIG_MISS, frame unaffected.
- Aborts: ADS_INIT_OK low during row 1 → IDLE next cycle, outputs 0. CLK_RST pulse during EXPOSE → all outputs 0 on the next edge, and a fresh trigger then runs a full frame.
